// File: rtl/alu_arb_seq.sv
// Two-port round-robin issue sequencer for the shared combinational ALU.
// Holds the operands for an opcode-dependent settle time, then returns the result over valid/ready.
module alu_arb_seq #(
  parameter int MUL_CYC = 2,
  parameter int DIV_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_opc,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_opc,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_opc,
  output logic [7:0] rsp_data,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_opc,
  input  logic [7:0] alu_out,
  input  logic       clr_halt,
  output logic       halted,
  output logic       busy
);

  localparam logic [3:0] OPC_NOP  = 4'h0;
  localparam logic [3:0] OPC_MUL  = 4'h6;
  localparam logic [3:0] OPC_DIV  = 4'h7;
  localparam logic [3:0] OPC_HALT = 4'hF;

  localparam int LMAX = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
  localparam int CW   = $clog2(LMAX + 1) + 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [3:0] opc;
    logic [7:0] a;
    logic [7:0] b;
  } req_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rr_q, rr_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_id_q, rsp_id_d;
  logic [3:0]    rsp_opc_q, rsp_opc_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic [7:0]    alu_a_q, alu_a_d;
  logic [7:0]    alu_b_q, alu_b_d;
  logic [3:0]    alu_opc_q, alu_opc_d;
  logic          halted_q, halted_d;

  req_t [1:0]    req;
  logic [1:0]    vld;
  logic          win, gnt, gnt_id;
  req_t          sel;

  function automatic logic [CW-1:0] lat_m1(input logic [3:0] opc);
    case (opc)
      OPC_MUL: lat_m1 = CW'(MUL_CYC - 1);
      OPC_DIV: lat_m1 = CW'(DIV_CYC - 1);
      default: lat_m1 = '0;
    endcase
  endfunction

  assign req[0] = '{opc: req0_opc, a: req0_a, b: req0_b};
  assign req[1] = '{opc: req1_opc, a: req1_a, b: req1_b};
  assign vld    = {req1_valid, req0_valid};

  // A grant can ride on the response handshake, so RESP->EXEC needs no idle cycle.
  assign win    = rst_n && !halted_q &&
                  ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
  assign gnt_id = (vld == 2'b11) ? rr_q : vld[1];
  assign gnt    = win && (|vld);
  assign sel    = req[gnt_id];

  assign req0_ready = gnt && !gnt_id;
  assign req1_ready = gnt && gnt_id;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_opc_d   = rsp_opc_q;
    rsp_data_d  = rsp_data_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_opc_d   = alu_opc_q;
    halted_d    = halted_q;

    case (state_q)
      EXEC: begin
        if (cnt_q == '0) begin
          rsp_data_d  = alu_out;
          rsp_opc_d   = alu_opc_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
          if (rsp_opc_q == OPC_HALT) halted_d = 1'b1;
        end
      end
      default: ;
    endcase

    if (gnt) begin
      alu_opc_d = sel.opc;
      alu_a_d   = sel.a;
      alu_b_d   = sel.b;
      rsp_id_d  = gnt_id;
      rr_d      = ~gnt_id;
      cnt_d     = lat_m1(sel.opc);
      state_d   = EXEC;
    end

    if (clr_halt) halted_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rr_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_opc_q   <= OPC_NOP;
      rsp_data_q  <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_opc_q   <= OPC_NOP;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_opc_q   <= rsp_opc_d;
      rsp_data_q  <= rsp_data_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_opc_q   <= alu_opc_d;
      halted_q    <= halted_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_opc   = rsp_opc_q;
  assign rsp_data  = rsp_data_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_opc   = alu_opc_q;
  assign halted    = halted_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arb_seq.sv
// Directed bench for alu_arb_seq with a behavioural 8-bit ALU on the alu_* port.
module tb_alu_arb_seq;

  localparam logic [3:0] NOP = 4'h0, ADD = 4'h1, SUB = 4'h2, MUL = 4'h6, DIV = 4'h7, HALT = 4'hF;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_opc, req1_opc;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [3:0] rsp_opc, alu_opc;
  logic [7:0] rsp_data, alu_a, alu_b, alu_out;
  logic       clr_halt, halted, busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_arb_seq #(.MUL_CYC(2), .DIV_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opc(req0_opc),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opc(req1_opc),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_opc(rsp_opc), .rsp_data(rsp_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opc(alu_opc), .alu_out(alu_out),
    .clr_halt(clr_halt), .halted(halted), .busy(busy)
  );

  // Shared combinational ALU model
  always_comb begin
    alu_out = 8'h00;
    case (alu_opc)
      ADD:  alu_out = alu_a + alu_b;
      SUB:  alu_out = alu_a - alu_b;
      MUL:  alu_out = alu_a * alu_b;
      DIV:  alu_out = (alu_b == 8'h00) ? 8'hFF : alu_a / alu_b;
      HALT: alu_out = alu_a;
      default: alu_out = 8'h00;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
    req0_valid = v; req0_opc = o; req0_a = a; req0_b = b;
  endtask

  task automatic drive1(input logic v, input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
    req1_valid = v; req1_opc = o; req1_a = a; req1_b = b;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0; clr_halt = 1'b0;
    drive0(1'b1, ADD, 8'h11, 8'h22);
    drive1(1'b0, NOP, 8'h00, 8'h00);
    tick(); tick();

    // Reset values
    chk("rst_rdy0", req0_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_opc", rsp_opc, NOP);
    chk("rst_alu_opc", alu_opc, NOP);
    chk("rst_alu_a", alu_a, 8'h00);
    chk("rst_halted_busy", {halted, busy}, 2'b00);
    drive0(1'b0, NOP, 8'h00, 8'h00);
    rst_n = 1'b1;
    tick();

    // Single ADD
    drive0(1'b1, ADD, 8'h3C, 8'h05);
    #1;
    chk("add_rdy", {req0_ready, req1_ready}, 2'b10);
    tick();
    drive0(1'b0, NOP, 8'h00, 8'h00);
    chk("add_exec", {busy, rsp_valid}, 2'b10);
    chk("add_alu", {alu_opc, alu_a, alu_b}, {ADD, 8'h3C, 8'h05});
    tick();
    chk("add_rsp", {rsp_valid, rsp_id, rsp_opc, rsp_data}, {1'b1, 1'b0, ADD, 8'h41});
    handshake();
    chk("add_idle", {rsp_valid, busy}, 2'b00);

    // Wrapping ADD on requester 1
    drive1(1'b1, ADD, 8'hF0, 8'h20);
    #1;
    chk("wrap_rdy", {req0_ready, req1_ready}, 2'b01);
    tick();
    drive1(1'b0, NOP, 8'h00, 8'h00);
    tick();
    chk("wrap_rsp", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b1, 8'h10});
    handshake();

    // Div: response 5 edges from grant cycle, operands held through EXEC
    drive1(1'b1, DIV, 8'h64, 8'h05);
    #1;
    chk("div_rdy", req1_ready, 1'b1);
    tick();
    drive1(1'b0, NOP, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) begin
      chk("div_exec", {rsp_valid, busy, alu_opc, alu_a, alu_b}, {1'b0, 1'b1, DIV, 8'h64, 8'h05});
      tick();
    end
    chk("div_rsp", {rsp_valid, rsp_id, rsp_opc, rsp_data}, {1'b1, 1'b1, DIV, 8'h14});

    // Backpressure with both requesters pending
    drive0(1'b1, ADD, 8'h01, 8'h02);
    drive1(1'b1, SUB, 8'h09, 8'h03);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_rdy", {req0_ready, req1_ready}, 2'b00);
      chk("bp_hold", {rsp_valid, rsp_id, rsp_opc, rsp_data, alu_opc, alu_a, alu_b},
          {1'b1, 1'b1, DIV, 8'h14, DIV, 8'h64, 8'h05});
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_rdy", {req0_ready, req1_ready}, 2'b10);
    tick();

    // Continuous contention with rsp_ready high: grants alternate, no idle cycle
    for (int k = 0; k < 4; k++) begin
      chk("arb_exec", {busy, rsp_valid}, 2'b10);
      tick();
      chk("arb_rsp", {rsp_valid, rsp_id, rsp_data},
          {1'b1, k[0], (k[0] ? 8'h06 : 8'h03)});
      chk("arb_rdy", {req0_ready, req1_ready}, (k[0] ? 2'b10 : 2'b01));
      tick();
    end
    drive0(1'b0, NOP, 8'h00, 8'h00);
    drive1(1'b0, NOP, 8'h00, 8'h00);
    tick();
    chk("arb_last", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b0, 8'h03});
    tick();
    rsp_ready = 1'b0;
    chk("arb_idle", {busy, rsp_valid}, 2'b00);

    // HALT from requester 1
    drive1(1'b1, HALT, 8'h07, 8'h00);
    #1;
    chk("halt_rdy", req1_ready, 1'b1);
    tick();
    drive1(1'b0, NOP, 8'h00, 8'h00);
    tick();
    chk("halt_rsp", {rsp_valid, rsp_opc, rsp_data, halted}, {1'b1, HALT, 8'h07, 1'b0});
    handshake();
    chk("halt_set", {halted, busy}, 2'b10);
    drive0(1'b1, ADD, 8'h10, 8'h20);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("halt_block", {req0_ready, halted}, 2'b01);
      tick();
    end
    clr_halt = 1'b1;
    tick();
    clr_halt = 1'b0;
    chk("halt_clr", halted, 1'b0);
    #1;
    chk("halt_regrant", req0_ready, 1'b1);
    tick();
    drive0(1'b0, NOP, 8'h00, 8'h00);
    tick();
    chk("post_halt_rsp", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b0, 8'h30});
    handshake();

    // clr_halt coincident with the HALT handshake wins
    drive1(1'b1, HALT, 8'h5A, 8'h00);
    tick();
    drive1(1'b0, NOP, 8'h00, 8'h00);
    tick();
    chk("halt2_rsp", {rsp_valid, rsp_data}, {1'b1, 8'h5A});
    rsp_ready = 1'b1; clr_halt = 1'b1;
    tick();
    rsp_ready = 1'b0; clr_halt = 1'b0;
    chk("halt2_clr_wins", {halted, busy}, 2'b00);

    // Mul: response 3 edges from grant cycle
    drive0(1'b1, MUL, 8'h07, 8'h06);
    #1;
    chk("mul_rdy", req0_ready, 1'b1);
    tick();
    drive0(1'b0, NOP, 8'h00, 8'h00);
    tick();
    chk("mul_wait", rsp_valid, 1'b0);
    tick();
    chk("mul_rsp", {rsp_valid, rsp_opc, rsp_data}, {1'b1, MUL, 8'h2A});
    handshake();

    // Reset in the middle of a Div
    drive1(1'b1, DIV, 8'h64, 8'h05);
    tick();
    drive1(1'b0, NOP, 8'h00, 8'h00);
    tick();
    chk("mid_busy", busy, 1'b1);
    drive0(1'b1, ADD, 8'h3C, 8'h05);
    drive1(1'b1, SUB, 8'h09, 8'h03);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rdy", {req0_ready, req1_ready}, 2'b00);
    chk("mid_rst_out", {rsp_valid, rsp_id, busy, alu_opc, alu_a, rsp_opc},
        {1'b0, 1'b0, 1'b0, NOP, 8'h00, NOP});
    tick();
    rst_n = 1'b1;
    #1;
    chk("mid_rst_prio", {req0_ready, req1_ready}, 2'b10);
    tick();
    drive0(1'b0, NOP, 8'h00, 8'h00);
    drive1(1'b0, NOP, 8'h00, 8'h00);
    tick();
    chk("mid_rst_add", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b0, 8'h41});
    handshake();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
